significand_divider: RTL and testbench
======================================

# significand_divider

Iterative radix-2 restoring divider for floating-point significands, the inverse datapath of the pipelined Booth significand multiplier in the same FP unit. It takes two 10-bit stored fractions with implicit leading one, plus per-operand zero flags. It produces a 24-bit fixed-point quotient with a sticky bit and special-case flags, at one quotient bit per clock, under a start/done handshake. Exponent handling, normalisation and rounding live downstream in the FP divide wrapper.

## Interface
- `FRAC_W`, default 10: stored fraction width per operand; significand is `1.frac`, `FRAC_W+1` bits.
- `Q_W`, default 24: quotient width; `q[Q_W-1]` is the integer bit (weight 1), the remainder are fraction bits.
- `CLK` input, 1 bit: single clock, rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request; sampled only when not busy.
- `a` input, `FRAC_W` bits: dividend fraction.
- `b` input, `FRAC_W` bits: divisor fraction.
- `azero` input, 1 bit: dividend is zero, so `a` is ignored.
- `bzero` input, 1 bit: divisor is zero, so `b` is ignored.
- `busy` output, 1 bit: iteration in progress.
- `done` output, 1 bit: one-cycle pulse; results are valid.
- `q` output, `Q_W` bits: quotient, held until the next accepted start.
- `sticky` output, 1 bit: final remainder is non-zero.
- `dz` output, 1 bit: divide by zero (`bzero & ~azero`).
- `inv` output, 1 bit: invalid, 0/0 (`azero & bzero`).

## Operation
- FSM states:
  - `IDLE`: `busy=0`, `done=0`. Next state `CALC`, or `FIN` for a special case.
  - `CALC`: `busy=1`. Loops for `Q_W` cycles, then goes to `FIN`.
  - `FIN`: `done=1` for exactly one cycle. Next state `IDLE`, or accepts a new start exactly as `IDLE` does.
- `start` is accepted only in `IDLE` or `FIN`; it is ignored in `CALC`.
- On accept, the dividend and divisor are latched:
  - `R = {0, 1, a}`, `FRAC_W+2` bits plus one guard bit.
  - `D = {1, b}`.
  - Bit counter set to `Q_W-1`.
  - `q`, `sticky`, `dz`, `inv` cleared.
- Special cases bypass `CALC` and go straight to `FIN`:
  - `inv`: `q = 0`, `inv = 1`.
  - `dz`: `q` all ones, `dz = 1`.
  - `azero` only: `q = 0`, `sticky = 0`.
- `CALC` iteration for counter `i`:
  - If `R >= D`: `q[i] = 1`, `R = R - D`; otherwise `q[i] = 0`.
  - Then `R = R << 1` and `i` decrements.
  - After `i = 0`: `sticky = |R` and the state goes to `FIN`.
- Width rules:
  - The quotient range is (0.5, 2), so `q[Q_W-1]` alone covers the integer part and no overflow is possible.
  - `R` never exceeds `2·D`, so `FRAC_W+3` bits suffice.
- `q` and the flags update only on the accept edge and inside `CALC`/`FIN`. They are stable from `done` until the next accept.

## Timing
- Reset values:
  - State `IDLE`.
  - `busy = 0`, `done = 0`.
  - `q = 0`, `sticky = 0`, `dz = 0`, `inv = 0`.
  - Counter 0.
- Normal operation latency:
  - `start` is sampled at edge n.
  - `busy` is high from after edge n through edge n+`Q_W`.
  - `done` is high between edge n+`Q_W` and n+`Q_W`+1 (24 cycles at defaults).
- Special-case latency: `done` is high in the cycle right after the accept edge n.
- Back-to-back: `start` high during the `FIN` cycle is accepted at that edge. `done` drops, and the next op starts with zero idle gap.
- `start` held high continuously: one op runs per `Q_W`+1 cycles.
- `RST` during `CALC` or `FIN`: all outputs return to reset values at that edge and the partial result is discarded. `start` sampled together with `RST` is ignored.
- Operand inputs need to be valid only at the accept edge.

## Structure
- Package `sigdiv_pkg`:
  - FSM state enum (`IDLE`, `CALC`, `FIN`).
  - Default widths 10 and 24.
  - Derived counter width `$clog2(Q_W)`.
- One natural sub-module, `sigdiv_step`: combinational compare/subtract/shift. Inputs `R` and `D`; outputs the next `R` and the quotient bit. It can be reused for a later unrolled radix-4 variant.
- The top level holds the FSM, counter and registers.

## Test plan
- `a=0`, `b=0` (1.0/1.0) → `done` at cycle 24, `q=24'h800000`, `sticky=0`, `dz=0`, `inv=0`.
- `a=10'h200`, `b=0` (1.5/1.0) → `q=24'hC00000`, `sticky=0`. Then `a=0`, `b=10'h200` (1/1.5) → `q=24'h555555`, `sticky=1`.
- `a=10'h3FF`, `b=0` → `q=24'hFFE000`, `sticky=0`. `a=0`, `b=10'h3FF` → `q[23]=0`, `q[22]=1`, `sticky=1`.
- Special cases, each with `done` one cycle after the accept edge:
  - `azero=1`, `bzero=0` → `q=0`.
  - `bzero=1`, `azero=0` → `dz=1`, `q=24'hFFFFFF`.
  - Both set → `inv=1`, `q=0`.
- `start` held high with changing operands → `start` ignored while `busy`. Next op accepted in the `FIN` cycle; `done` pulses every 25 cycles; each `q` matches its operands.
- `RST` asserted at cycle 10 of an op → next edge: `busy=0`, `q=0`, no `done` pulse. A subsequent op computes correctly.

Source files
------------

// File: rtl/significand_divider_pkg.sv
// Shared types and default widths for the radix-2 significand divider.
package sigdiv_pkg;

   // Default stored-fraction and quotient widths
   localparam int FRAC_W_DEF = 10;
   localparam int Q_W_DEF    = 24;

   // Bit-counter width for a given quotient width
   function automatic int cnt_w(input int qw);
      return (qw > 1) ? $clog2(qw) : 1;
   endfunction

   // Divider control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/significand_divider_step.sv
// One restoring-division step: conditional subtract then shift left.
// Kept separate so an unrolled higher-radix variant can chain several.
module sigdiv_step #(
   parameter int R_W = 13
) (
   input  logic [R_W-1:0] i_r,
   input  logic [R_W-1:0] i_d,
   output logic [R_W-1:0] o_r,
   output logic           o_q
);

   logic           w_ge;
   logic [R_W-1:0] w_diff;
   logic [R_W-1:0] w_rem;

   // Compare, restore-or-subtract, then shift the partial remainder
   always_comb begin
      w_ge   = (i_r >= i_d);
      w_diff = i_r - i_d;
      w_rem  = w_ge ? w_diff : i_r;
      o_r    = {w_rem[R_W-2:0], 1'b0};
      o_q    = w_ge;
   end

endmodule

// File: rtl/significand_divider.sv
// Iterative radix-2 restoring divider for 1.frac significands.
// One quotient bit per clock, start/done handshake, special-case bypass.
module significand_divider
   import sigdiv_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int Q_W    = Q_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [FRAC_W-1:0] a,
   input  logic [FRAC_W-1:0] b,
   input  logic              azero,
   input  logic              bzero,
   output logic              busy,
   output logic              done,
   output logic [Q_W-1:0]    q,
   output logic              sticky,
   output logic              dz,
   output logic              inv
);

   // Remainder holds up to 2*D, so one bit above the 1.frac significand
   // plus a guard bit is enough.
   localparam int R_W   = FRAC_W + 3;
   localparam int CNT_W = cnt_w(Q_W);

   state_t           r_state;
   logic [R_W-1:0]   r_r;
   logic [R_W-1:0]   r_d;
   logic [CNT_W-1:0] r_cnt;
   logic [Q_W-1:0]   r_q;
   logic             r_busy;
   logic             r_done;
   logic             r_sticky;
   logic             r_dz;
   logic             r_inv;

   logic [R_W-1:0]   w_r_nxt;
   logic             w_qbit;

   sigdiv_step #(.R_W(R_W)) u_step (
      .i_r (r_r),
      .i_d (r_d),
      .o_r (w_r_nxt),
      .o_q (w_qbit)
   );

   // Control FSM with registered outputs; accept is legal in IDLE and FIN
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_r      <= '0;
         r_d      <= '0;
         r_cnt    <= '0;
         r_q      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sticky <= 1'b0;
         r_dz     <= 1'b0;
         r_inv    <= 1'b0;
      end else begin
         case (r_state)
            IDLE, FIN: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               if (start) begin
                  r_r      <= {2'b00, 1'b1, a};
                  r_d      <= {2'b00, 1'b1, b};
                  r_cnt    <= CNT_W'(Q_W - 1);
                  r_q      <= '0;
                  r_sticky <= 1'b0;
                  r_dz     <= 1'b0;
                  r_inv    <= 1'b0;
                  if (azero && bzero) begin
                     r_inv   <= 1'b1;
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end else if (bzero) begin
                     r_q     <= '1;
                     r_dz    <= 1'b1;
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end else if (azero) begin
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= CALC;
                     r_busy  <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_q[r_cnt] <= w_qbit;
               r_r        <= w_r_nxt;
               if (r_cnt == '0) begin
                  r_sticky <= |w_r_nxt;
                  r_state  <= FIN;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign q      = r_q;
   assign sticky = r_sticky;
   assign dz     = r_dz;
   assign inv    = r_inv;

endmodule

// File: tb/tb_significand_divider.sv
// Directed table-driven bench for significand_divider plus handshake,
// back-to-back and mid-operation reset sequences.
module tb_significand_divider;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  a = '0;
   logic [9:0]  b = '0;
   logic        azero = 1'b0;
   logic        bzero = 1'b0;
   logic        busy, done, sticky, dz, inv;
   logic [23:0] q;

   int n_cmp = 0;
   int n_err = 0;

   significand_divider #(.FRAC_W(10), .Q_W(24)) dut (
      .CLK(CLK), .RST(RST), .start(start), .a(a), .b(b),
      .azero(azero), .bzero(bzero), .busy(busy), .done(done),
      .q(q), .sticky(sticky), .dz(dz), .inv(inv)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [9:0]  a;
      logic [9:0]  b;
      logic        az;
      logic        bz;
      logic [23:0] q;
      logic        st;
      logic        dz;
      logic        inv;
      int          lat;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Accept one op, wait for done (bounded), compare latency and results
   task automatic run_op(input vec_t v, input int idx);
      int lat;
      @(negedge CLK);
      start = 1'b1; a = v.a; b = v.b; azero = v.az; bzero = v.bz;
      @(posedge CLK); #1;
      start = 1'b0; a = $urandom; b = $urandom; azero = 1'b0; bzero = 1'b0;
      check($sformatf("v%0d_busy", idx), busy, (v.lat != 0));
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
      end
      check($sformatf("v%0d_lat", idx), lat, v.lat);
      check($sformatf("v%0d_q", idx), q, v.q);
      check($sformatf("v%0d_sticky", idx), sticky, v.st);
      check($sformatf("v%0d_dz", idx), dz, v.dz);
      check($sformatf("v%0d_inv", idx), inv, v.inv);
      @(posedge CLK); #1;
      check($sformatf("v%0d_done_pulse", idx), done, 1'b0);
   endtask

   initial begin
      vec_t  ops[3];
      int    cyc, k, prev;
      logic  saw_done;

      //           a       b       az    bz    q             st    dz    inv   lat
      tbl[0]  = '{10'h000, 10'h000, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 24};
      tbl[1]  = '{10'h200, 10'h000, 1'b0, 1'b0, 24'hC00000, 1'b0, 1'b0, 1'b0, 24};
      tbl[2]  = '{10'h000, 10'h200, 1'b0, 1'b0, 24'h555555, 1'b1, 1'b0, 1'b0, 24};
      tbl[3]  = '{10'h3FF, 10'h000, 1'b0, 1'b0, 24'hFFE000, 1'b0, 1'b0, 1'b0, 24};
      tbl[4]  = '{10'h000, 10'h3FF, 1'b0, 1'b0, 24'h400801, 1'b1, 1'b0, 1'b0, 24};
      tbl[5]  = '{10'h100, 10'h100, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 24};
      tbl[6]  = '{10'h080, 10'h200, 1'b0, 1'b0, 24'h600000, 1'b0, 1'b0, 1'b0, 24};
      tbl[7]  = '{10'h000, 10'h100, 1'b0, 1'b0, 24'h666666, 1'b1, 1'b0, 1'b0, 24};
      tbl[8]  = '{10'h3FF, 10'h123, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 0};
      tbl[9]  = '{10'h155, 10'h000, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 0};
      tbl[10] = '{10'h0AA, 10'h055, 1'b1, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1, 0};
      tbl[11] = '{10'h200, 10'h000, 1'b0, 1'b0, 24'hC00000, 1'b0, 1'b0, 1'b0, 24};

      // Reset with start asserted: nothing may be accepted
      RST = 1'b1; start = 1'b1; a = 10'h200;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_q", q, 24'h0);
      check("rst_flags", {sticky, dz, inv}, 3'b000);
      @(negedge CLK); RST = 1'b0; start = 1'b0;
      @(posedge CLK); #1;
      check("post_rst_idle", busy, 1'b0);

      for (int i = 0; i < 12; i++) run_op(tbl[i], i);

      // Result held while idle
      repeat (5) @(posedge CLK);
      #1;
      check("hold_q", q, 24'hC00000);
      check("hold_done", done, 1'b0);

      // Start held high: operands valid only at accept edges, garbage otherwise
      ops[0] = tbl[1]; ops[1] = tbl[2]; ops[2] = tbl[5];
      @(negedge CLK);
      start = 1'b1; a = ops[0].a; b = ops[0].b;
      @(posedge CLK); #1;
      cyc = 0; k = 0; prev = 0;
      while (k < 3 && cyc < 200) begin
         if (done) begin
            check($sformatf("b2b%0d_q", k), q, ops[k].q);
            check($sformatf("b2b%0d_sticky", k), sticky, ops[k].st);
            check($sformatf("b2b%0d_gap", k), cyc - prev, (k == 0) ? 24 : 25);
            prev = cyc;
            k++;
            if (k < 3) begin
               a = ops[k].a; b = ops[k].b;
            end else begin
               start = 1'b0;
            end
         end else begin
            a = $urandom; b = $urandom;
         end
         @(posedge CLK); #1;
         cyc++;
      end
      check("b2b_count", k, 3);
      start = 1'b0;
      @(posedge CLK); #1;
      check("b2b_idle", busy, 1'b0);

      // Reset mid-operation, with start sampled alongside reset
      @(negedge CLK);
      start = 1'b1; a = 10'h200; b = 10'h000;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1; start = 1'b1;
      @(posedge CLK); #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_q", q, 24'h0);
      check("midrst_done", done, 1'b0);
      @(negedge CLK);
      RST = 1'b0; start = 1'b0;
      saw_done = 1'b0;
      repeat (30) begin
         @(posedge CLK); #1;
         if (done || busy) saw_done = 1'b1;
      end
      check("midrst_no_done", saw_done, 1'b0);
      run_op(tbl[2], 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
